soc_ahb3_sram_bridge: RTL and testbench

AHB3-Lite slave that sits directly downstream of the AHB3 master multiplexer. It takes the multiplexed slave-side bus and drives a single-port synchronous SRAM with a 1-cycle read latency. Reads complete with zero wait states. A read that immediately follows a write takes one wait state. Illegal transfers get the two-cycle AHB ERROR response.

---
 rtl/soc_ahb3_pkg.sv | 28 ++
 rtl/soc_ahb3_be_gen.sv | 35 +++
 rtl/soc_ahb3_sram_bridge.sv | 137 +++++++++++++
 tb/tb_soc_ahb3_sram_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the SRAM bridge state constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package soc_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bridge FSM encoding, kept as plain constants so older tools can read it.
    typedef logic [2:0] bridge_state_t;
    localparam bridge_state_t ST_IDLE   = 3'd0;
    localparam bridge_state_t ST_WRITE  = 3'd1;
    localparam bridge_state_t ST_READ   = 3'd2;
    localparam bridge_state_t ST_RSTALL = 3'd3;
    localparam bridge_state_t ST_ERR1   = 3'd4;
    localparam bridge_state_t ST_ERR2   = 3'd5;

endpackage

// File: rtl/soc_ahb3_be_gen.sv
// Byte-lane enables and size/alignment error flag from HSIZE and low HADDR bits.
// Latency: purely combinational.
// Backpressure: none; evaluated every address phase.
module soc_ahb3_be_gen #(
    parameter int XLEN = 32
) (
    input  logic [2:0]                     i_hsize,
    input  logic [$clog2(XLEN/8)-1:0]      i_addr_lsb,
    output logic [XLEN/8-1:0]              o_be,
    output logic                           o_err
);
    localparam int SW   = XLEN / 8;
    localparam int ALSB = $clog2(SW);

    logic [ALSB-1:0] w_mask;
    logic            w_oversize;
    logic            w_misalign;
    logic [SW-1:0]   w_lane;

    // A transfer wider than the bus, or with nonzero offset bits below its size, is illegal.
    assign w_oversize = i_hsize > 3'(ALSB);
    assign w_mask     = ~({ALSB{1'b1}} << i_hsize);
    assign w_misalign = |(i_addr_lsb & w_mask);
    assign o_err      = w_oversize | w_misalign;

    // A lane is enabled when it falls in the same size-aligned block as the address.
    always_comb begin
        for (int i = 0; i < SW; i++) begin
            w_lane[i] = ((ALSB'(i) >> i_hsize) == (i_addr_lsb >> i_hsize));
        end
    end

    assign o_be = o_err ? '0 : w_lane;

endmodule

// File: rtl/soc_ahb3_sram_bridge.sv
// AHB3-Lite slave driving a single-port synchronous SRAM (1-cycle read latency).
// Latency: reads zero-wait, read directly after write one wait, errors two-cycle response.
// Backpressure: HREADYOUT low only in the read-after-write stall and first error cycle.
module soc_ahb3_sram_bridge
    import soc_ahb3_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int PLEN = 32,
    parameter  int AW   = 10,
    localparam int SW   = XLEN >> 3,
    localparam int ALSB = $clog2(SW)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hsel_i,
    input  logic [PLEN-1:0]   haddr_i,
    input  logic [XLEN-1:0]   hwdata_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    input  logic [SW-1:0]     hprot_i,
    input  logic [1:0]        htrans_i,
    input  logic              hmastlock_i,
    input  logic              hready_i,
    output logic [XLEN-1:0]   hrdata_o,
    output logic              hready_o,
    output logic              hresp_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [SW-1:0]     sram_be_o,
    output logic [AW-1:0]     sram_addr_o,
    output logic [XLEN-1:0]   sram_wdata_o,
    input  logic [XLEN-1:0]   sram_rdata_i
);

    bridge_state_t   r_state;
    bridge_state_t   w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [SW-1:0]   r_be;

    logic [SW-1:0]   w_be;
    logic            w_err;
    logic            w_hready;
    logic            w_accept;
    logic            w_rd_now;
    logic [AW-1:0]   w_word;
    logic            w_unused;

    // Burst type, protection, lock and the address bits above the SRAM depth carry no meaning here.
    assign w_unused = ^{hburst_i, hprot_i, hmastlock_i, haddr_i[PLEN-1:AW+ALSB]};

    soc_ahb3_be_gen #(
        .XLEN (XLEN)
    ) u_be_gen (
        .i_hsize    (hsize_i),
        .i_addr_lsb (haddr_i[ALSB-1:0]),
        .o_be       (w_be),
        .o_err      (w_err)
    );

    assign w_hready = (r_state != ST_ERR1) && (r_state != ST_RSTALL);
    assign w_accept = hsel_i & hready_i & htrans_i[1] & w_hready;
    assign w_word   = haddr_i[AW+ALSB-1:ALSB];
    // A read can use the port in its own address phase unless a write data phase owns it.
    assign w_rd_now = w_accept & ~w_err & ~hwrite_i & (r_state != ST_WRITE);

    // Next-state decode; errors win over any read/write decoding.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_RSTALL: w_state_nxt = ST_READ;
            ST_ERR1:   w_state_nxt = ST_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (hwrite_i) begin
                        w_state_nxt = ST_WRITE;
                    end else if (r_state == ST_WRITE) begin
                        w_state_nxt = ST_RSTALL;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture word address and lanes of every legal accepted transfer for its data phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
            r_be   <= '0;
        end else if (w_accept && !w_err) begin
            r_addr <= w_word;
            r_be   <= w_be;
        end
    end

    // SRAM port mux: write data phase, late read, or same-cycle read; all strobes held low in reset.
    always_comb begin
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (!rst_i) begin
            if (r_state == ST_WRITE) begin
                sram_ce_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_be_o    = r_be;
                sram_addr_o  = r_addr;
                sram_wdata_o = hwdata_i;
            end else if (r_state == ST_RSTALL) begin
                sram_ce_o   = 1'b1;
                sram_addr_o = r_addr;
            end else if (w_rd_now) begin
                sram_ce_o   = 1'b1;
                sram_addr_o = w_word;
            end
        end
    end

    assign hready_o = w_hready;
    assign hresp_o  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata_o = (r_state == ST_READ) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_soc_ahb3_sram_bridge.sv
// Self-checking bench for soc_ahb3_sram_bridge: hand sequences, a vector table, random traffic.
// Latency: n/a.
// Backpressure: the bench master honours HREADYOUT (hready_i tied to hready_o).
module tb_soc_ahb3_sram_bridge;
    import soc_ahb3_pkg::*;

    localparam int XLEN = 32;
    localparam int PLEN = 32;
    localparam int AW   = 10;
    localparam int SW   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              hsel_i;
    logic [PLEN-1:0]   haddr_i;
    logic [XLEN-1:0]   hwdata_i;
    logic              hwrite_i;
    logic [2:0]        hsize_i;
    logic [2:0]        hburst_i;
    logic [SW-1:0]     hprot_i;
    logic [1:0]        htrans_i;
    logic              hmastlock_i;
    logic              hready_i;
    logic [XLEN-1:0]   hrdata_o;
    logic              hready_o;
    logic              hresp_o;
    logic              sram_ce_o;
    logic              sram_we_o;
    logic [SW-1:0]     sram_be_o;
    logic [AW-1:0]     sram_addr_o;
    logic [XLEN-1:0]   sram_wdata_o;
    logic [XLEN-1:0]   sram_rdata_i;

    always #5 clk_i = ~clk_i;
    assign hready_i = hready_o;

    soc_ahb3_sram_bridge #(.XLEN(XLEN), .PLEN(PLEN), .AW(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hsel_i       (hsel_i),
        .haddr_i      (haddr_i),
        .hwdata_i     (hwdata_i),
        .hwrite_i     (hwrite_i),
        .hsize_i      (hsize_i),
        .hburst_i     (hburst_i),
        .hprot_i      (hprot_i),
        .htrans_i     (htrans_i),
        .hmastlock_i  (hmastlock_i),
        .hready_i     (hready_i),
        .hrdata_o     (hrdata_o),
        .hready_o     (hready_o),
        .hresp_o      (hresp_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_be_o    (sram_be_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    // SRAM behavioural model: one-cycle read latency, byte-enabled writes.
    logic [31:0] sram_mem [0:1023];
    logic        mem_clr;
    always @(posedge clk_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 32'h0;
            sram_rdata_i <= 32'h0;
        end else if (sram_ce_o) begin
            if (sram_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (sram_be_o[i]) sram_mem[sram_addr_o][8*i +: 8] <= sram_wdata_o[8*i +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    typedef struct {
        logic        hsel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_resp;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        xf [0:511];
    int          nv;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  ref_mem [0:1023][0:3];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tv(input logic hsel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic eresp,
                      input int ewaits, input logic [31:0] erdata);
        xf[nv].hsel = hsel;   xf[nv].trans = trans;  xf[nv].wr = wr;
        xf[nv].size = size;   xf[nv].addr = addr;    xf[nv].wdata = wdata;
        xf[nv].exp_resp = eresp; xf[nv].exp_waits = ewaits; xf[nv].exp_rdata = erdata;
        nv++;
    endtask

    task automatic ap(input logic hsel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr);
        hsel_i = hsel; htrans_i = trans; hwrite_i = wr; hsize_i = size; haddr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pipelined AHB master: address phase of xf[k] overlaps data phase of the previous transfer.
    task automatic run(input int n);
        int   k;
        int   dp;
        int   waits;
        int   guard;
        logic acc;
        k = 0; dp = -1; waits = 0; guard = 0;
        while ((k < n || dp >= 0) && guard < 20 * n + 50) begin
            guard++;
            if (k < n) ap(xf[k].hsel, xf[k].trans, xf[k].wr, xf[k].size, xf[k].addr);
            else       ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
            hwdata_i = (dp >= 0 && xf[dp].wr) ? xf[dp].wdata : 32'h0;
            @(negedge clk_i);
            acc = hready_o;
            if (dp < 0) begin
                chk("idle_hready", k, 32'(hready_o), 32'd1);
                chk("idle_hresp",  k, 32'(hresp_o),  32'd0);
                chk("idle_hrdata", k, hrdata_o,      32'h0);
            end else if (!hready_o) begin
                waits++;
                if (waits > 4) begin
                    chk("stall_bound", dp, 32'(waits), 32'(xf[dp].exp_waits));
                    acc = 1'b1;
                end
            end else begin
                chk("hresp", dp, 32'(hresp_o), 32'(xf[dp].exp_resp));
                chk("waits", dp, 32'(waits),   32'(xf[dp].exp_waits));
                if (!xf[dp].wr && !xf[dp].exp_resp)
                    chk("hrdata", dp, hrdata_o, xf[dp].exp_rdata);
            end
            tick();
            if (acc) begin
                dp = (k < n && xf[k].hsel && xf[k].trans[1]) ? k : -1;
                if (k < n) k++;
                waits = 0;
            end
        end
        if (k < n || dp >= 0) chk("run_timeout", k, 32'd1, 32'd0);
    endtask

    // Reference model: transaction-ordered byte memory plus the wait/error rules.
    task automatic gen_random(input int n);
        int prev_wr;
        prev_wr = 0;
        nv = 0;
        for (int k = 0; k < n; k++) begin
            logic        hsel, wr, err;
            logic [1:0]  trans;
            logic [2:0]  size;
            logic [31:0] addr, wdata, rd;
            int          waits, word, lo;
            hsel  = ($urandom_range(0, 9) != 0);
            trans = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            wr    = 1'($urandom_range(0, 1));
            size  = 3'($urandom_range(0, 3));
            addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            wdata = $urandom;
            err = 1'b0; waits = 0; rd = 32'h0;
            if (hsel && trans[1]) begin
                err  = (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
                word = int'((addr / 4) % 1024);
                lo   = int'(addr % 4);
                if (err) begin
                    waits = 1;
                    prev_wr = 0;
                end else if (wr) begin
                    for (int b = lo; b < lo + (1 << size); b++) ref_mem[word][b] = wdata[8*b +: 8];
                    prev_wr = 1;
                end else begin
                    waits = prev_wr;
                    rd = {ref_mem[word][3], ref_mem[word][2], ref_mem[word][1], ref_mem[word][0]};
                    prev_wr = 0;
                end
            end else begin
                prev_wr = 0;
            end
            tv(hsel, trans, wr, size, addr, wdata, err, waits, rd);
        end
    endtask

    task automatic clear_mems();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 4; j++) ref_mem[i][j] = 8'h0;
    endtask

    initial begin
        rst_i = 1'b1; mem_clr = 1'b1;
        hburst_i = 3'd0; hprot_i = '0; hmastlock_i = 1'b0; hwdata_i = 32'h0;
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);

        // Reset state.
        repeat (2) @(negedge clk_i);
        chk("rst_hready", 0, 32'(hready_o),  32'd1);
        chk("rst_hresp",  0, 32'(hresp_o),   32'd0);
        chk("rst_hrdata", 0, hrdata_o,       32'h0);
        chk("rst_ce",     0, 32'(sram_ce_o), 32'd0);
        tick();
        rst_i = 1'b0; mem_clr = 1'b0;

        // IDLE transfers with hsel high: zero-wait OKAY, no SRAM activity.
        ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("idle_ce",     c, 32'(sram_ce_o), 32'd0);
            chk("idle_hready", c, 32'(hready_o),  32'd1);
            chk("idle_hresp",  c, 32'(hresp_o),   32'd0);
            tick();
        end

        // Word write then word read at 0x10: SRAM strobes and the single stall.
        ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        @(negedge clk_i);
        chk("wr_addr_ph_ce", 0, 32'(sram_ce_o), 32'd0);
        tick();
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        hwdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        chk("wr_ce",    0, 32'(sram_ce_o),   32'd1);
        chk("wr_we",    0, 32'(sram_we_o),   32'd1);
        chk("wr_addr",  0, 32'(sram_addr_o), 32'd4);
        chk("wr_be",    0, 32'(sram_be_o),   32'hF);
        chk("wr_wdata", 0, sram_wdata_o,     32'hDEADBEEF);
        tick();
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        hwdata_i = 32'h0;
        @(negedge clk_i);
        chk("rstall_hready", 0, 32'(hready_o),    32'd0);
        chk("rstall_ce",     0, 32'(sram_ce_o),   32'd1);
        chk("rstall_we",     0, 32'(sram_we_o),   32'd0);
        chk("rstall_addr",   0, 32'(sram_addr_o), 32'd4);
        chk("rstall_be",     0, 32'(sram_be_o),   32'd0);
        tick();
        @(negedge clk_i);
        chk("rd_hready", 0, 32'(hready_o), 32'd1);
        chk("rd_hrdata", 0, hrdata_o,      32'hDEADBEEF);
        tick();

        // Misaligned halfword read: two-cycle ERROR, no SRAM access.
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HWORD, 32'h01);
        @(negedge clk_i);
        chk("err_addr_ce", 0, 32'(sram_ce_o), 32'd0);
        tick();
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk_i);
        chk("err1_hready", 0, 32'(hready_o),  32'd0);
        chk("err1_hresp",  0, 32'(hresp_o),   32'd1);
        chk("err1_ce",     0, 32'(sram_ce_o), 32'd0);
        tick();
        @(negedge clk_i);
        chk("err2_hready", 0, 32'(hready_o),  32'd1);
        chk("err2_hresp",  0, 32'(hresp_o),   32'd1);
        chk("err2_ce",     0, 32'(sram_ce_o), 32'd0);
        tick();

        // Vector table: {hsel, htrans, write, size, addr, wdata, exp hresp, exp waits, exp rdata}.
        nv = 0;
        tv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h10,   32'hDEADBEEF, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        0, 1, 32'hDEADBEEF);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h10,   32'h11223344, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,  32'h13,   32'hAA5A5A5A, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h00,   32'h0,        0, 1, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        0, 0, 32'hAA223344);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_HWORD, 32'h01,   32'h0,        1, 1, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h00,   32'h0,        1, 1, 32'h0);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h20,   32'h1,        0, 0, 32'h0);
        tv(1, HTRANS_SEQ,    1, HSIZE_WORD,  32'h24,   32'h2,        0, 0, 32'h0);
        tv(1, HTRANS_SEQ,    1, HSIZE_WORD,  32'h28,   32'h3,        0, 0, 32'h0);
        tv(1, HTRANS_SEQ,    1, HSIZE_WORD,  32'h2C,   32'h4,        0, 0, 32'h0);
        tv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h20,   32'h0,        0, 0, 32'h1);
        tv(1, HTRANS_SEQ,    0, HSIZE_WORD,  32'h24,   32'h0,        0, 0, 32'h2);
        tv(1, HTRANS_SEQ,    0, HSIZE_WORD,  32'h28,   32'h0,        0, 0, 32'h3);
        tv(1, HTRANS_SEQ,    0, HSIZE_WORD,  32'h2C,   32'h0,        0, 0, 32'h4);
        tv(1, HTRANS_BUSY,   0, HSIZE_WORD,  32'h30,   32'h0,        0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h1010, 32'h55,       0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        0, 1, 32'h55);
        tv(0, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h10,   32'hFFFFFFFF, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        0, 0, 32'h55);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_HWORD, 32'h12,   32'hBEEF0000, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,  32'h10,   32'h000000A5, 0, 0, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h10,   32'h0,        0, 1, 32'hBEEF00A5);
        tv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h16,   32'h12345678, 1, 1, 32'h0);
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h14,   32'h0,        0, 0, 32'h0);
        run(nv);

        // Asynchronous reset while stalled in the late-read state.
        ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        hwdata_i = 32'hCAFEF00D;
        tick();
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        hwdata_i = 32'h0;
        #2;
        chk("pre_rst_hready", 0, 32'(hready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        chk("async_rst_hready", 0, 32'(hready_o),  32'd1);
        chk("async_rst_ce",     0, 32'(sram_ce_o), 32'd0);
        chk("async_rst_hresp",  0, 32'(hresp_o),   32'd0);
        tick();
        rst_i = 1'b0;
        nv = 0;
        tv(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0, 0, 32'hCAFEF00D);
        run(nv);

        // Randomized traffic against the reference model.
        clear_mems();
        gen_random(400);
        run(nv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
